elastic_pipe_reg: RTL and testbench
===================================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (1..512).
REQ-002 SHALL have parameter SKID_EN, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-003 SHALL have parameter CLEAR_DATA, default 1; 1 = payload registers cleared to 0 on reset/flush, 0 = payload retained and only valid bits cleared.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held entries at the next edge.
REQ-007 SHALL have port stall  input  1  freeze the stage with no transfer on either side.
REQ-008 SHALL have port in_valid  input  1  upstream entry offered.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-011 SHALL have port out_valid  output  1  head entry offered downstream.
REQ-012 SHALL have port out_data  output  WIDTH  head payload, driven from a register.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the head.
REQ-014 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 SHALL hold entries in a main register (head) and, when SKID_EN=1, a skid register; each entry has its own valid bit.
REQ-016 SHALL define an input transfer as in_valid & in_ready, and an output transfer as out_valid & out_ready.
REQ-017 SHALL drive out_valid = main_valid & ~stall & ~flush, and out_data = main payload.
REQ-018 SHALL drive in_ready = ~skid_valid & ~stall & ~flush when SKID_EN=1 (no combinational path from out_ready).
REQ-019 SHALL drive in_ready = (~main_valid | out_ready) & ~stall & ~flush when SKID_EN=0.
REQ-020 SHALL keep entries in strict FIFO order; the skid entry is always younger than main.
REQ-021 SHALL, on an input transfer with main empty, or with main being transferred out while skid is empty, load main at the next edge (latency 1 cycle in to out).
REQ-022 SHALL, on an input transfer while main is held (valid, no output transfer), load skid.
REQ-023 SHALL, on an output transfer with skid valid, move skid to main and clear skid, or refill skid if a simultaneous input transfer occurs.
REQ-024 SHALL, on simultaneous input and output transfers with occupancy 1, leave occupancy at 1 and make main the new entry.
REQ-025 SHALL never overwrite a valid entry and never lose an accepted entry except by flush or reset.
REQ-026 SHALL, while stall=1 and flush=0, hold all registers unchanged, independent of in_valid and out_ready.
REQ-027 SHALL, on flush=1, clear both valid bits at the next edge; flush overrides stall and any input presented that cycle.
REQ-028 SHALL, when CLEAR_DATA=1, zero both payload registers on flush; when CLEAR_DATA=0, leave payloads unchanged.
REQ-029 SHALL drive occupancy = main_valid + skid_valid from registered state; it never exceeds 1 when SKID_EN=0.
REQ-030 SHALL sustain one transfer per cycle when out_ready is held high and in_valid is held high.

Reset
REQ-031 SHALL, on reset=1 at an edge, clear main_valid and skid_valid; reset has priority over flush and stall.
REQ-032 SHALL, after reset, present out_valid=0, occupancy=0, in_ready=1 (stall=0, flush=0), and out_data=0 when CLEAR_DATA=1.
REQ-033 SHALL, on reset asserted mid-operation with occupancy 2, discard both entries and output out_valid=0 in the next cycle.

Verification
REQ-034 SHALL pass streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the following cycles, occupancy stays 1.
REQ-035 SHALL pass backpressure: SKID_EN=1, out_ready=0, push 0xA,0xB -> occupancy 2, in_ready=0; set out_ready=1 -> 0xA then 0xB emitted in order.
REQ-036 SHALL pass stall: occupancy 1 holding 0x5, stall=1 for 3 cycles with in_valid=1 and out_ready=1 -> out_valid=0, in_ready=0, then 0x5 is emitted after stall drops.
REQ-037 SHALL pass flush priority: occupancy 2, flush=1 and stall=1 with in_valid=1 (0x77) -> next cycle occupancy 0 and out_data=0 (CLEAR_DATA=1), and 0x77 never emitted.
REQ-038 SHALL pass SKID_EN=0 pass-through: main holds 0x9, out_ready=1, in_valid=1 with 0xC -> in_ready=1 in the same cycle and 0xC emitted next cycle.
REQ-039 SHALL pass reset mid-burst: occupancy 2, reset=1 for 1 cycle -> out_valid=0, occupancy=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: a head entry plus an optional skid entry, with
// stall/flush control and valid/ready handshakes on both sides.
module elastic_pipe_reg #(
  parameter int WIDTH      = 64,
  parameter int SKID_EN    = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_xfer, out_xfer;

  always_comb begin
    if (SKID_EN != 0) begin
      in_ready = ~skid_valid_q & ~stall & ~flush;
    end else begin
      in_ready = (~main_valid_q | out_ready) & ~stall & ~flush;
    end
  end

  assign out_valid = main_valid_q & ~stall & ~flush;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Stall needs no explicit branch: both transfers are already gated off.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (reset || flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_data_d = in_data;
        end
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) begin
          main_data_d = in_data;
        end
      end
    end else if (in_xfer) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
    if (SKID_EN == 0) begin
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    main_valid_q <= main_valid_d;
    main_data_q  <= main_data_d;
    skid_valid_q <= skid_valid_d;
    skid_data_q  <= skid_data_d;
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: a skid instance and a single-entry
// instance share stimulus; each task checks one behaviour.
module tb_elastic_pipe_reg;

  logic       clk;
  logic       reset, flush, stall, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic       in_ready0, out_valid0;
  logic [7:0] out_data0;
  logic [1:0] occupancy0;
  int total = 0;
  int bad = 0;

  elastic_pipe_reg #(.WIDTH(8), .SKID_EN(1), .CLEAR_DATA(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  elastic_pipe_reg #(.WIDTH(8), .SKID_EN(0), .CLEAR_DATA(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); end
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin bad++; $display("[TB] FAIL stream_data%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("[TB] FAIL stream_occ%0d got=%0d exp=1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL stream_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    tick();
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_first got=%0d/%b exp=1/1", occupancy, in_ready); end
    in_data = 8'h0B;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== 2'd2) begin bad++; $display("[TB] FAIL bp_occ2 got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0A) begin bad++; $display("[TB] FAIL bp_head0 got=%b/%h exp=1/0a", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0B || occupancy !== 2'd1) begin bad++; $display("[TB] FAIL bp_head1 got=%b/%h/%0d exp=1/0b/1", out_valid, out_data, occupancy); end
    tick();
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0d/%b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    tick();
    stall = 1'b1; in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_hs%0d got=%b/%b exp=0/0", i, out_valid, in_ready); end
      tick();
      total++; if (occupancy !== 2'd1 || out_data !== 8'h05) begin bad++; $display("[TB] FAIL stall_hold%0d got=%0d/%h exp=1/05", i, occupancy, out_data); end
    end
    stall = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h05) begin bad++; $display("[TB] FAIL stall_release got=%b/%h exp=1/05", out_valid, out_data); end
    tick();
    total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL stall_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("[TB] FAIL flush_fill got=%0d exp=2", occupancy); end
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_hs got=%b/%b exp=0/0", in_ready, out_valid); end
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (occupancy !== 2'd0 || out_data !== 8'h00 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_clear got=%0d/%h/%b exp=0/00/0", occupancy, out_data, out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no77_%0d got=%b/%h exp=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h09;
    tick();
    total++; if (occupancy0 !== 2'd1 || in_ready0 !== 1'b0) begin bad++; $display("[TB] FAIL pt_hold got=%0d/%b exp=1/0", occupancy0, in_ready0); end
    out_ready = 1'b1; in_data = 8'h0C;
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("[TB] FAIL pt_in_ready got=%b exp=1", in_ready0); end
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h09) begin bad++; $display("[TB] FAIL pt_head got=%b/%h exp=1/09", out_valid0, out_data0); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h0C || occupancy0 !== 2'd1) begin bad++; $display("[TB] FAIL pt_next got=%b/%h/%0d exp=1/0c/1", out_valid0, out_data0, occupancy0); end
    tick();
    total++; if (occupancy0 !== 2'd0 || occupancy !== 2'd0) begin bad++; $display("[TB] FAIL pt_drain got=%0d/%0d exp=0/0", occupancy0, occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h41;
    tick();
    in_data = 8'h42;
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("[TB] FAIL rmid_fill got=%0d exp=2", occupancy); end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_state got=%b/%0d/%b exp=0/0/1", out_valid, occupancy, in_ready); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL rmid_data got=%h exp=00", out_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_passthrough();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
